inst_prefetch_queue: RTL

- Fetch front end between a multi-cycle instruction memory (req/ack handshake) and the IF/ID pipeline register.
- Keeps its own fetch PC and issues one word request at a time.
- Buffers up to DEPTH fetched words together with their PC+4 values, and hands them to IF/ID.
- Honours a hold from the hazard unit and a redirect from the branch-resolution logic, which flushes the queue and squashes in-flight fetches.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fifo_sync.sv | 57 +++++
 rtl/inst_prefetch_queue.sv | 114 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch front end: FSM encoding,
// the NOP word handed to IF/ID when nothing is queued, and the PC step.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [31:0] NOP_WORD = 32'h0;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous circular-buffer FIFO with push/pop/flush and occupancy outputs.
// Read data is the raw head slot; the consumer gates it with empty_o.
module fifo_sync #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full buffer is accepted only when the head leaves the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, runs one memory request at a
// time and buffers fetched words with their PC+4 for the IF/ID register.
module inst_prefetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        hold,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc4,
  output state_e      dbg_state
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // Handshakes: mem_req/mem_addr stay stable until the cycle mem_ack is seen,
  // which completes the request. inst_valid offers the head entry, which is
  // consumed on any clock where inst_valid=1, hold=0 and redirect=0.
  state_e      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] pend_pc_q;

  logic [31:0]   target_pc;
  logic [31:0]   pc_plus4;
  logic          push;
  logic          pop;
  logic          slot_free;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          full;
  logic          empty;
  logic [63:0]   head;

  assign target_pc   = word_align(redirect_pc);
  assign pc_plus4    = fetch_pc_q + PC_STEP;
  assign pop         = !empty && !hold && !redirect;
  assign push        = (state_q == ST_REQ) && mem_ack && !redirect && (!full || pop);
  assign count_after = count + CW'(push) - CW'(pop);
  assign slot_free   = (count_after < CW'(DEPTH));

  fifo_sync #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i ({pc_plus4, mem_rdata}),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // In DRAIN fetch_pc_q still holds the squashed address; the redirect target
  // waits in pend_pc_q until the outstanding request completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (redirect) fetch_pc_q <= target_pc;
          if (redirect || slot_free) state_q <= ST_REQ;
        end
        ST_REQ: begin
          if (mem_ack) begin
            if (redirect) begin
              fetch_pc_q <= target_pc;
              state_q    <= ST_IDLE;
            end else begin
              fetch_pc_q <= pc_plus4;
              if (!slot_free) state_q <= ST_IDLE;
            end
          end else if (redirect) begin
            pend_pc_q <= target_pc;
            state_q   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (mem_ack) begin
            fetch_pc_q <= redirect ? target_pc : pend_pc_q;
            state_q    <= ST_IDLE;
          end else if (redirect) begin
            pend_pc_q <= target_pc;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req    = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign mem_addr   = fetch_pc_q;
  assign inst_valid = !empty;
  assign inst       = empty ? NOP_WORD : head[31:0];
  assign inst_pc4   = empty ? 32'h0 : head[63:32];
  assign dbg_state  = state_q;

endmodule
